z16_mem_arbiter: RTL and testbench
==================================

# z16_mem_arbiter

Single-port memory arbiter for the Z16 core. Shares one synchronous 16-bit-wide word memory between the instruction-fetch requester and the data (LOAD/STORE) requester. Data has priority, and a starvation counter guarantees fetch progress. Sits between the Z16 fetch/execute logic and the unified program/data RAM, replacing separate combinational instruction storage.

## Interface
Parameters:
- STARVE_LIMIT, default 3: number of consecutive contested cycles data may win before fetch is forced through; range 0..15.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_if_req  in  1  fetch requests a read this cycle
- i_if_addr  in  16  fetch byte address; bit 0 ignored
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  16  fetch read data; 0 when o_if_rvalid low
- i_d_req  in  1  data requests an access this cycle
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  16  data byte address; bit 0 ignored
- i_d_wdata  in  16  store data
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid  out  1  load data valid (never asserted for stores)
- o_d_rdata  out  16  load data; 0 when o_d_rvalid low
- o_mem_en  out  1  memory access this cycle
- o_mem_we  out  1  memory write strobe
- o_mem_addr  out  15  word address (= winning byte address [15:1])
- o_mem_wdata  out  16  write data
- i_mem_rdata  in  16  memory read data, valid one cycle after o_mem_en with o_mem_we low

## Operation
- Grant decision is combinational from requests and registered state.
  - Only one request: that requester wins.
  - Both requesting, starve_cnt < STARVE_LIMIT: data wins.
  - Both requesting, starve_cnt == STARVE_LIMIT: fetch wins.
  - STARVE_LIMIT = 0: fetch always wins contests.
- The winner gets gnt = 1 the same cycle. o_mem_en = 1, o_mem_addr/o_mem_we/o_mem_wdata come from the winner.
  - For fetch: o_mem_we = 0, o_mem_wdata = 0.
  - With no winner, all o_mem_* = 0.
- Requester protocol:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - A request withdrawn before gnt is legal and is simply dropped.
- Read return:
  - Registered tag rd_owner ∈ {NONE, FETCH, DATA} records the owner of a granted read.
  - Next cycle, the matching o_*_rvalid = 1 and o_*_rdata = i_mem_rdata.
  - Stores set rd_owner = NONE.
- starve_cnt (4 bits):
  - Increments when both request and data wins.
  - Clears when fetch wins or i_if_req is low.
  - Saturates at STARVE_LIMIT.
- Back-to-back accesses every cycle are supported: a new grant may coincide with the previous read's rvalid.

## Timing
- Reset (i_rst_n low, asynchronous): rd_owner = NONE, starve_cnt = 0. While reset is asserted, all gnt, rvalid, rdata and o_mem_* outputs are 0.
- Reset asserted with a read outstanding: that read's rvalid is never produced.
- First grant is possible in the first cycle after i_rst_n deasserts.
- Read latency: gnt in cycle N → rvalid and rdata in cycle N+1, exactly one cycle. Store is complete at the cycle-N clock edge.
- Throughput: one access per cycle in total. Under sustained contention, fetch gets at least 1 of every STARVE_LIMIT+1 cycles.
- Simultaneous events:
  - Load granted in N followed by fetch granted in N+1: o_d_rvalid(N+1) and o_if_rvalid(N+2), with no overlap.
  - o_if_rvalid and o_d_rvalid are never both high.

## Structure
- Shared package z16_pkg holds:
  - Z16_WORD_W = 16
  - Z16_ADDR_W = 16
  - owner enum z16_owner_t {OWN_NONE, OWN_FETCH, OWN_DATA}
- Single module; no sub-module. The starvation counter and owner tag are inline.

## Test plan
- Fetch only: i_if_req = 1 with addr 0x0000, 0x0002, 0x0004 on consecutive cycles → o_mem_addr 0, 1, 2; o_if_rvalid each next cycle with the preloaded words 0x0010, 0x0020, 0x0519.
- Store then load: data store 0x240B to addr 0x007A, then load 0x007A → o_mem_we = 1 with o_mem_addr = 0x3D; next access returns o_d_rdata = 0x240B one cycle after its gnt; o_d_rvalid is low for the store.
- Contention with STARVE_LIMIT = 3, both requesting continuously for 8 cycles → grant pattern D, D, D, F, D, D, D, F.
- STARVE_LIMIT = 0, both requesting → fetch granted every cycle and data never granted; on dropping i_if_req, data is granted the same cycle.
- Odd address: fetch addr 0x0005 → o_mem_addr = 0x0002.
- Reset mid-operation: assert i_rst_n low between the grant of a load and its return → no o_d_rvalid; all outputs 0; starve_cnt = 0 after release. The next contest gives data the grant.

Source files
------------

// File: rtl/z16_pkg.sv
// Z16 shared widths and types.
// Word/address widths, read-owner tag, byte-to-word address helper.
package z16_pkg;

   localparam int Z16_WORD_W = 16;
   localparam int Z16_ADDR_W = 16;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DATA
   } z16_owner_t;

   // Byte address to word address; bit 0 is dropped.
   function automatic logic [Z16_ADDR_W-2:0] word_addr(
      input logic [Z16_ADDR_W-1:0] a
   );
      return a[Z16_ADDR_W-1:1];
   endfunction

endpackage

// File: rtl/z16_mem_arbiter.sv
// Single-port memory arbiter: fetch vs data, data priority with starvation guard.
// Ports: fetch req/addr/gnt/rvalid/rdata, data req/we/addr/wdata/gnt/rvalid/rdata,
// memory en/we/addr/wdata/rdata (one-cycle read latency).
module z16_mem_arbiter
   import z16_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_if_req,
   input  logic [Z16_ADDR_W-1:0] i_if_addr,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [Z16_WORD_W-1:0] o_if_rdata,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [Z16_ADDR_W-1:0] i_d_addr,
   input  logic [Z16_WORD_W-1:0] i_d_wdata,
   output logic                  o_d_gnt,
   output logic                  o_d_rvalid,
   output logic [Z16_WORD_W-1:0] o_d_rdata,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [Z16_ADDR_W-2:0] o_mem_addr,
   output logic [Z16_WORD_W-1:0] o_mem_wdata,
   input  logic [Z16_WORD_W-1:0] i_mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   z16_owner_t rd_owner;
   logic [3:0] starve_cnt;
   logic       d_win;
   logic       f_win;

   // Gating with i_rst_n keeps every grant and strobe low during reset.
   always_comb begin
      d_win = i_rst_n && i_d_req
              && (!i_if_req || (starve_cnt < LIMIT));
      f_win = i_rst_n && i_if_req && !d_win;
   end

   always_comb begin
      o_if_gnt    = f_win;
      o_d_gnt     = d_win;
      o_mem_en    = f_win || d_win;
      o_mem_we    = d_win && i_d_we;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (d_win) begin
         o_mem_addr  = word_addr(i_d_addr);
         o_mem_wdata = i_d_wdata;
      end else if (f_win) begin
         o_mem_addr  = word_addr(i_if_addr);
      end
   end

   always_comb begin
      o_if_rvalid = (rd_owner == OWN_FETCH);
      o_d_rvalid  = (rd_owner == OWN_DATA);
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_owner   <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         unique case (1'b1)
            f_win:             rd_owner <= OWN_FETCH;
            d_win && !i_d_we:  rd_owner <= OWN_DATA;
            default:           rd_owner <= OWN_NONE;
         endcase
         // Counts only contested cycles that data won.
         if (d_win && i_if_req)
            starve_cnt <= (starve_cnt < LIMIT)
                          ? starve_cnt + 4'd1 : starve_cnt;
         else
            starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Bench for z16_mem_arbiter: grant checks per scenario, read-return scoreboard.
// A second instance with STARVE_LIMIT = 0 shares the request inputs.
module tb_z16_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [15:0] if_rdata, d_rdata;
   logic        mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;

   logic        z_if_gnt, z_if_rvalid, z_d_gnt, z_d_rvalid;
   logic [15:0] z_if_rdata, z_d_rdata;
   logic        z_mem_en, z_mem_we;
   logic [14:0] z_mem_addr;
   logic [15:0] z_mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic mon_on = 1'b0;

   typedef struct {
      int          due;
      bit          is_data;
      logic [15:0] data;
   } rd_t;
   rd_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   z16_mem_arbiter #(.STARVE_LIMIT(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
      .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   z16_mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(z_if_gnt), .o_if_rvalid(z_if_rvalid),
      .o_if_rdata(z_if_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
      .i_d_wdata(d_wdata),
      .o_d_gnt(z_d_gnt), .o_d_rvalid(z_d_rvalid), .o_d_rdata(z_d_rdata),
      .o_mem_en(z_mem_en), .o_mem_we(z_mem_we), .o_mem_addr(z_mem_addr),
      .o_mem_wdata(z_mem_wdata), .i_mem_rdata(mem_rdata)
   );

   // Memory model: preloaded words, stores kept in a side array.
   logic [15:0] st_data [1024];
   bit          st_vld  [1024];

   function automatic logic [15:0] init_word(input logic [9:0] a);
      case (a)
         10'd0:   return 16'h0010;
         10'd1:   return 16'h0020;
         10'd2:   return 16'h0519;
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            st_data[mem_addr[9:0]] <= mem_wdata;
            st_vld[mem_addr[9:0]]  <= 1'b1;
         end else begin
            mem_rdata <= st_vld[mem_addr[9:0]] ? st_data[mem_addr[9:0]]
                                                : init_word(mem_addr[9:0]);
         end
      end
   end

   // Read-return scoreboard.
   rd_t         e;
   logic        exp_if, exp_d;
   logic [15:0] exp_rd;

   always @(negedge clk) begin
      #4;
      if (mon_on) begin
         exp_if = 1'b0;
         exp_d  = 1'b0;
         exp_rd = 16'h0;
         while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL sb_stale due %0d at cycle %0d", e.due, cyc);
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            exp_if = !e.is_data;
            exp_d  = e.is_data;
            exp_rd = e.data;
         end
         n_checks++;
         if ({if_rvalid, d_rvalid} !== {exp_if, exp_d}) begin
            n_fail++;
            $display("FAIL rvalid cyc %0d got if=%b d=%b want if=%b d=%b",
                     cyc, if_rvalid, d_rvalid, exp_if, exp_d);
         end
         n_checks++;
         if (if_rdata !== (exp_if ? exp_rd : 16'h0)
             || d_rdata !== (exp_d ? exp_rd : 16'h0)) begin
            n_fail++;
            $display("FAIL rdata cyc %0d got if=%h d=%h want %h",
                     cyc, if_rdata, d_rdata, exp_rd);
         end
      end
   end

   task automatic idle();
      if_req = 1'b0; if_addr = 16'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
   endtask

   task automatic test_reset();
      if_req = 1'b1; if_addr = 16'h0002;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h007A; d_wdata = 16'h0;
      repeat (2) @(negedge clk);
      mon_on = 1'b1;
      #4;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_ctrl got %b want 0000",
                  {if_gnt, d_gnt, mem_en, mem_we});
      end
      n_checks++;
      if (mem_addr !== 15'h0 || mem_wdata !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mem got addr=%h wdata=%h want 0",
                  mem_addr, mem_wdata);
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_fetch_only();
      logic [15:0] words [3] = '{16'h0010, 16'h0020, 16'h0519};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         if_req = 1'b1; if_addr = 16'(2 * i);
         #4;
         n_checks++;
         if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin
            n_fail++;
            $display("FAIL fetch_ctrl %0d got %b want 1010", i,
                     {if_gnt, d_gnt, mem_en, mem_we});
         end
         n_checks++;
         if (mem_addr !== 15'(i) || mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL fetch_addr %0d got %h/%h want %h/0", i,
                     mem_addr, mem_wdata, 15'(i));
         end
         q.push_back('{due: cyc + 1, is_data: 1'b0, data: words[i]});
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_store_load();
      @(negedge clk);
      idle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h007A; d_wdata = 16'h240B;
      #4;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0111) begin
         n_fail++;
         $display("FAIL store_ctrl got %b want 0111",
                  {if_gnt, d_gnt, mem_en, mem_we});
      end
      n_checks++;
      if (mem_addr !== 15'h3D || mem_wdata !== 16'h240B) begin
         n_fail++;
         $display("FAIL store_mem got %h/%h want 3d/240b",
                  mem_addr, mem_wdata);
      end
      @(negedge clk);
      idle();
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h007A;
      #4;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {4'b0110, 15'h3D})
      begin
         n_fail++;
         $display("FAIL load_ctrl got %b/%h want 0110/3d",
                  {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
      end
      q.push_back('{due: cyc + 1, is_data: 1'b1, data: 16'h240B});
      @(negedge clk);
      idle();
      #4;
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== 33'd0) begin
         n_fail++;
         $display("FAIL idle_mem got en=%b we=%b addr=%h wdata=%h want 0",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_contention();
      logic [7:0] fpat = 8'b1000_1000;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 16'h0004;
         d_req = 1'b1; d_we = 1'b0; d_addr = 16'h007A; d_wdata = 16'h0;
         #4;
         n_checks++;
         if ({if_gnt, d_gnt} !== {fpat[i], !fpat[i]}
             || mem_addr !== (fpat[i] ? 15'h2 : 15'h3D)) begin
            n_fail++;
            $display("FAIL contest %0d got f=%b d=%b a=%h want f=%b",
                     i, if_gnt, d_gnt, mem_addr, fpat[i]);
         end
         q.push_back('{due: cyc + 1, is_data: !fpat[i],
                       data: fpat[i] ? 16'h0519 : 16'h240B});
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_starve_zero();
      logic f;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if_req = (i < 4); if_addr = 16'h0002;
         d_req = 1'b1; d_we = 1'b0; d_addr = 16'h007A; d_wdata = 16'h0;
         #4;
         n_checks++;
         if ({z_if_gnt, z_d_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL zero_limit %0d got f=%b d=%b", i,
                     z_if_gnt, z_d_gnt);
         end
         f = (i == 3);
         n_checks++;
         if ({if_gnt, d_gnt} !== {f, !f}) begin
            n_fail++;
            $display("FAIL limit3_mix %0d got f=%b d=%b want f=%b", i,
                     if_gnt, d_gnt, f);
         end
         q.push_back('{due: cyc + 1, is_data: !f,
                       data: f ? 16'h0020 : 16'h240B});
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_odd_addr();
      @(negedge clk);
      idle();
      if_req = 1'b1; if_addr = 16'h0005;
      #4;
      n_checks++;
      if (if_gnt !== 1'b1 || mem_addr !== 15'h2) begin
         n_fail++;
         $display("FAIL odd_addr got gnt=%b addr=%h want 1/2",
                  if_gnt, mem_addr);
      end
      q.push_back('{due: cyc + 1, is_data: 1'b0, data: 16'h0519});
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 16'h0000;
         d_req = 1'b1; d_we = 1'b0; d_addr = 16'h007A; d_wdata = 16'h0;
         #4;
         n_checks++;
         if ({if_gnt, d_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_rst %0d got f=%b d=%b want 01", i,
                     if_gnt, d_gnt);
         end
         if (i < 2)
            q.push_back('{due: cyc + 1, is_data: 1'b1, data: 16'h240B});
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'd0
          || {mem_addr, mem_wdata, if_rdata, d_rdata} !== 63'd0) begin
         n_fail++;
         $display("FAIL mid_rst got g=%b%b en=%b rv=%b%b rd=%h",
                  if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, d_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      n_checks++;
      if ({if_gnt, d_gnt} !== 2'b01) begin
         n_fail++;
         $display("FAIL post_rst got f=%b d=%b want 01", if_gnt, d_gnt);
      end
      q.push_back('{due: cyc + 1, is_data: 1'b1, data: 16'h240B});
      @(negedge clk);
      idle();
      @(negedge clk);
      #5;
      n_checks++;
      if (q.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_drain got %0d left want 0", q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      idle();
      #1;
      rst_n = 1'b0;
      test_reset();
      test_fetch_only();
      test_store_load();
      test_contention();
      test_starve_zero();
      test_odd_addr();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
